box_display_fx: RTL
===================

// Module: box_display_fx
// PURPOSE
//  Parametrised successor to the single-pixel outline box generator for the 1024x768-class
//  pixel pipeline (hcount4/vcount_in domain). Draws one rectangle with configurable border
//  thickness. Modes: off / outline / outline+solid fill / blinking outline, plus a select
//  highlight. Mode and select are latched only at frame boundaries (no tearing). Blink timing
//  comes from an internal frame counter. Output is a 12-bit RGB pixel for the top-level OR/mux.
// PARAMETERS
//  BOX_START_X   none     left edge, inclusive, hcount4 units
//  BOX_END_X     none     right edge, inclusive
//  BOX_START_Y   none     top edge, inclusive, vcount_in units
//  BOX_END_Y     none     bottom edge, inclusive
//  BORDER_W      1        border thickness in pixels, >=1
//  BOX_COLOR     12'h555  normal border colour
//  HILITE_COLOR  12'hFFF  border colour while selected
//  FILL_COLOR    12'h111  interior colour in fill mode
//  BLINK_FRAMES  30       frames per blink half-period, >=1
// PORTS
//  clk_in          in   1   pixel clock
//  rst_in          in   1   reset: asynchronous, active-high
//  hcount4         in   12  horizontal pixel count
//  vcount_in       in   11  vertical pixel count
//  frame_start_in  in   1   one-cycle pulse at start of each frame
//  mode_in         in   2   0=off 1=outline 2=outline+fill 3=blink outline
//  select_in       in   1   1 = draw border in HILITE_COLOR
//  box_pixel_out   out  12  RGB pixel, 0 when not drawn
//  in_box_out      out  1   pixel lies inside outer rectangle (any mode), aligned with box_pixel_out
// BEHAVIOUR
//  Reset (async assert, sync release): box_pixel_out=0, in_box_out=0, mode_q=0 (off),
//   sel_q=0, frame_cnt=0, blink_phase=0 (visible), both pipeline stages cleared.
//  Regions, inclusive compares, unsigned:
//   outer  = START_X<=h<=END_X && START_Y<=v<=END_Y
//   inner  = START_X+BORDER_W<=h<=END_X-BORDER_W && same for Y
//   border = outer && !inner. fill = inner. If 2*BORDER_W exceeds the box width or height,
//   inner is empty and the whole box is border. Compute bounds at elaboration.
//  Pipeline: stage1 registers outer/border/fill flags from hcount4/vcount_in.
//   Stage2 registers the colour mux. Latency is exactly 2 clk_in cycles for every mode,
//   including mode 0.
//  Colour mux (stage2), border colour bc = sel_q ? HILITE_COLOR : BOX_COLOR:
//   mode 0: 0 everywhere
//   mode 1: border->bc, else 0
//   mode 2: border->bc, fill->FILL_COLOR, else 0
//   mode 3: border && blink_phase==0 -> bc, else 0
//   in_box_out = delayed outer flag regardless of mode.
//  Frame latch: on the frame_start_in cycle, mode_q<=mode_in and sel_q<=select_in.
//   New values affect pixels whose stage2 update is in the following cycle or later.
//   Between pulses, changes on mode_in/select_in are ignored.
//  Blink counter (on frame_start_in only):
//   - If mode_in==3 and mode_q!=3 (entering blink): frame_cnt<=0, blink_phase<=0.
//   - Else if frame_cnt==BLINK_FRAMES-1: frame_cnt<=0, blink_phase toggles.
//   - Else frame_cnt++.
//   BLINK_FRAMES=1 toggles every frame. The counter free-runs in all modes.
//   frame_cnt width = $clog2(BLINK_FRAMES+1).
//  Reset mid-frame: outputs go to 0 immediately (async). Drawing resumes only after the
//   next frame_start_in latches a mode. Until then mode_q=0, so the output stays blank.
// TESTING
//  1 Reset, then mode_in=1, pulse frame_start. Box 100..200 x 50..80, BORDER_W=1.
//    Sweep a frame: BOX_COLOR only where h in {100,200} or v in {50,80}, 2 cycles late.
//  2 BORDER_W=3, mode 2: (102,60)->12'h555, (103,60)->12'h111, (99,60)->0,
//    in_box_out=1 at (100,50), 0 at (201,50).
//  3 BLINK_FRAMES=2, enter mode 3: frames 0-1 border drawn, frames 2-3 blank,
//    frames 4-5 drawn. Re-enter mode 3 from mode 1: phase restarts visible.
//  4 select_in toggled mid-frame: border colour unchanged until next frame_start,
//    then 12'hFFF. Mode change mid-frame is likewise deferred.
//  5 Assert rst_in mid-frame in mode 2: outputs 0 same cycle. After release, output stays 0
//    until a frame_start with mode_in!=0.
//  6 Degenerate box 10..13 wide, BORDER_W=3, mode 2: every in-box pixel is BOX_COLOR,
//    never FILL_COLOR.

Source files
------------

// File: rtl/box_display_fx_if.sv
// Pixel-pipeline bus between the video timing source and the box overlay:
// raster position, frame pulse, per-frame controls and the overlay result.
interface box_display_fx_if;
  logic [11:0] hcount4;
  logic [10:0] vcount_in;
  logic        frame_start_in;
  logic [1:0]  mode_in;
  logic        select_in;
  logic [11:0] box_pixel_out;
  logic        in_box_out;

  modport master (
    output hcount4, vcount_in, frame_start_in, mode_in, select_in,
    input  box_pixel_out, in_box_out
  );

  modport slave (
    input  hcount4, vcount_in, frame_start_in, mode_in, select_in,
    output box_pixel_out, in_box_out
  );
endinterface

// File: rtl/box_display_fx.sv
// Rectangle overlay with configurable border thickness, fill, blink and select
// highlight; two-stage pipeline, controls latched only on frame_start_in.
module box_display_fx #(
  parameter int          BOX_START_X  = 0,
  parameter int          BOX_END_X    = 0,
  parameter int          BOX_START_Y  = 0,
  parameter int          BOX_END_Y    = 0,
  parameter int          BORDER_W     = 1,
  parameter logic [11:0] BOX_COLOR    = 12'h555,
  parameter logic [11:0] HILITE_COLOR = 12'hFFF,
  parameter logic [11:0] FILL_COLOR   = 12'h111,
  parameter int          BLINK_FRAMES = 30
) (
  input logic             clk_in,
  input logic             rst_in,
  box_display_fx_if.slave bus
);

  localparam int CW = $clog2(BLINK_FRAMES + 1);

  // A border thicker than half the box swallows the interior entirely.
  localparam bit INNER_EN = ((2 * BORDER_W) <= (BOX_END_X - BOX_START_X + 1)) &&
                            ((2 * BORDER_W) <= (BOX_END_Y - BOX_START_Y + 1));

  localparam logic [11:0] X_LO    = 12'(BOX_START_X);
  localparam logic [11:0] X_HI    = 12'(BOX_END_X);
  localparam logic [10:0] Y_LO    = 11'(BOX_START_Y);
  localparam logic [10:0] Y_HI    = 11'(BOX_END_Y);
  localparam logic [11:0] X_IN_LO = INNER_EN ? 12'(BOX_START_X + BORDER_W) : 12'd0;
  localparam logic [11:0] X_IN_HI = INNER_EN ? 12'(BOX_END_X - BORDER_W)   : 12'd0;
  localparam logic [10:0] Y_IN_LO = INNER_EN ? 11'(BOX_START_Y + BORDER_W) : 11'd0;
  localparam logic [10:0] Y_IN_HI = INNER_EN ? 11'(BOX_END_Y - BORDER_W)   : 11'd0;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_OUTLINE = 2'd1;
  localparam logic [1:0] MODE_FILL    = 2'd2;
  localparam logic [1:0] MODE_BLINK   = 2'd3;

  typedef enum logic {PH_SHOW = 1'b0, PH_HIDE = 1'b1} phase_e;

  logic          outer_s, inner_s;
  logic          outer_r, border_r, fill_r;
  logic [1:0]    mode_r;
  logic          sel_r;
  logic [11:0]   bc_s, color_s;
  logic [11:0]   pixel_r;
  logic          in_box_r;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  phase_e        phase_r, phase_nxt_s;

  // Region decode of the current raster position
  always_comb begin
    outer_s = (bus.hcount4 >= X_LO) && (bus.hcount4 <= X_HI) &&
              (bus.vcount_in >= Y_LO) && (bus.vcount_in <= Y_HI);
    inner_s = INNER_EN &&
              (bus.hcount4 >= X_IN_LO) && (bus.hcount4 <= X_IN_HI) &&
              (bus.vcount_in >= Y_IN_LO) && (bus.vcount_in <= Y_IN_HI);
  end

  // Stage 1: region flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      outer_r  <= 1'b0;
      border_r <= 1'b0;
      fill_r   <= 1'b0;
    end else begin
      outer_r  <= outer_s;
      border_r <= outer_s & ~inner_s;
      fill_r   <= inner_s;
    end
  end

  // Per-frame control latch; mid-frame changes on the inputs are ignored
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mode_r <= MODE_OFF;
      sel_r  <= 1'b0;
    end else if (bus.frame_start_in) begin
      mode_r <= bus.mode_in;
      sel_r  <= bus.select_in;
    end else begin
      mode_r <= mode_r;
      sel_r  <= sel_r;
    end
  end

  // Blink phase/counter next state; entering blink restarts on the visible phase
  always_comb begin
    cnt_nxt_s   = cnt_r;
    phase_nxt_s = phase_r;
    if (bus.frame_start_in) begin
      if ((bus.mode_in == MODE_BLINK) && (mode_r != MODE_BLINK)) begin
        cnt_nxt_s   = {CW{1'b0}};
        phase_nxt_s = PH_SHOW;
      end else if (cnt_r == CW'(BLINK_FRAMES - 1)) begin
        cnt_nxt_s   = {CW{1'b0}};
        phase_nxt_s = (phase_r == PH_SHOW) ? PH_HIDE : PH_SHOW;
      end else begin
        cnt_nxt_s   = cnt_r + CW'(1);
        phase_nxt_s = phase_r;
      end
    end else begin
      cnt_nxt_s   = cnt_r;
      phase_nxt_s = phase_r;
    end
  end

  // Blink state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_r   <= {CW{1'b0}};
      phase_r <= PH_SHOW;
    end else begin
      cnt_r   <= cnt_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  // Colour selection from the stage-1 flags and latched controls
  always_comb begin
    bc_s    = sel_r ? HILITE_COLOR : BOX_COLOR;
    color_s = 12'h000;
    case (mode_r)
      MODE_OFF: color_s = 12'h000;
      MODE_OUTLINE: begin
        if (border_r) color_s = bc_s;
        else          color_s = 12'h000;
      end
      MODE_FILL: begin
        if (border_r)    color_s = bc_s;
        else if (fill_r) color_s = FILL_COLOR;
        else             color_s = 12'h000;
      end
      MODE_BLINK: begin
        if (border_r && (phase_r == PH_SHOW)) color_s = bc_s;
        else                                  color_s = 12'h000;
      end
      default: color_s = 12'h000;
    endcase
  end

  // Stage 2: registered pixel and aligned outer flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_r  <= 12'h000;
      in_box_r <= 1'b0;
    end else begin
      pixel_r  <= color_s;
      in_box_r <= outer_r;
    end
  end

  assign bus.box_pixel_out = pixel_r;
  assign bus.in_box_out    = in_box_r;

endmodule
